cell_plotter: RTL and testbench
===============================

CELL_PLOTTER -- requirements
Module: cell_plotter

Interface
REQ-001 Parameters SHALL be, one per line:
- GRID_W, 4, cell columns.
- GRID_H, 4, cell rows.
- CELL_SIZE, 4, pixels per cell side.
- X_ORIGIN, 0, pixel x of cell (0,0).
- Y_ORIGIN, 0, pixel y of cell (0,0).
- FIFO_DEPTH, 8, queued cell updates (power of 2).
REQ-002 Ports SHALL be, one per line:
- clock  input  1  rising-edge clock.
- reset_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  cell update offered.
- in_ready  output  1  update can be accepted.
- in_x  input  8  cell column.
- in_y  input  8  cell row.
- in_colour  input  3  cell colour.
- clear_req  input  1  one-cycle request to blank the whole grid.
- plot  output  1  pixel write strobe to the VGA adapter.
- out_x  output  8  pixel x.
- out_y  output  8  pixel y.
- out_colour  output  3  pixel colour.
- busy  output  1  work pending or in progress.
- dropped_count  output  8  out-of-range updates discarded.

Function
REQ-003 Accept an update on a clock edge when in_valid=1 and in_ready=1; store {in_x, in_y, in_colour} in a FIFO_DEPTH-entry FIFO.
REQ-004 in_ready SHALL be 1 exactly when the FIFO holds fewer than FIFO_DEPTH entries.
REQ-005 A push and a pop on the same edge SHALL leave the occupancy unchanged and lose no data.
REQ-006 The FSM SHALL have three states: IDLE, PAINT and CLEAR.
REQ-007 clear_req=1 in IDLE or PAINT SHALL set clear_pending; clear_req=1 while in CLEAR is ignored.
REQ-008 IDLE with clear_pending=1 SHALL go to CLEAR and clear clear_pending; clear has priority over the FIFO.
REQ-009 IDLE with the FIFO non-empty and clear_pending=0 SHALL pop the head entry into the current-cell registers.
REQ-010 If the popped entry is in range (x<GRID_W and y<GRID_H), the FSM SHALL go to PAINT; otherwise it SHALL stay in IDLE and increment dropped_count, saturating at 255.
REQ-011 PAINT SHALL plot CELL_SIZE*CELL_SIZE pixels in row-major order (px inner), one per cycle, with plot=1.
- out_x = X_ORIGIN + cx*CELL_SIZE + px
- out_y = Y_ORIGIN + cy*CELL_SIZE + py
- out_colour = current colour
REQ-012 After the last PAINT pixel (px=py=CELL_SIZE-1), the FSM SHALL return to IDLE; the next cell SHALL start no earlier than the following IDLE cycle.
REQ-013 CLEAR SHALL plot every pixel of the GRID_W*CELL_SIZE by GRID_H*CELL_SIZE rectangle at the origin, row-major, with colour 3'b000 and plot=1; it then returns to IDLE.
REQ-014 FIFO contents SHALL be retained through CLEAR and painted afterwards, in arrival order.
REQ-015 plot, out_x, out_y and out_colour SHALL be driven from flops only, with no combinational path from any input.
- out_* hold their last value while plot=0.
REQ-016 Latency: an update accepted at edge E0 into an empty FIFO while in IDLE with no clear pending SHALL give its first plot=1 in the cycle after edge E0+2.
REQ-017 Coordinate arithmetic SHALL be 8-bit; elaboration SHALL fail unless X_ORIGIN+GRID_W*CELL_SIZE<=160 and Y_ORIGIN+GRID_H*CELL_SIZE<=120.
REQ-018 busy SHALL be 1 when the state is not IDLE, or the FIFO is non-empty, or clear_pending=1.

Reset
REQ-019 On reset_n=0 at an edge, the block SHALL:
- empty the FIFO and abandon any PAINT or CLEAR in progress;
- enter IDLE;
- set plot=0, out_x=0, out_y=0, out_colour=0, busy=0, dropped_count=0 and clear_pending=0;
- set in_ready=1 in the following cycle.
REQ-020 Updates offered while reset_n=0 SHALL NOT be accepted.

Verification
REQ-021 The bench SHALL cover the following directed scenarios, with default parameters:
- Push (1,2,3'b111) -> 16 plot cycles, x 4..7 inner, y 8..11, colour 7; first plot the cycle after edge E0+2; busy=0 afterwards.
- Push 9 updates back-to-back during PAINT -> in_ready=0 while 8 are stored; all 9 painted in order; none lost.
- Push (4,0,7) -> no plot; dropped_count=1; busy returns to 0.
- Queue 2 updates then pulse clear_req while IDLE -> 256 plots of colour 0 over x,y 0..15 first, then both cells painted.
- reset_n=0 at pixel 5 of a PAINT -> plot=0 next cycle; in_ready=1; busy=0; queued entries never painted.
- Push during a pop with 3 entries queued -> occupancy stays 3; paint order preserved.

Source files
------------

// File: rtl/cell_plotter.sv
// Cell plotter: queues cell updates and paints each cell as a square of
// pixels for a VGA adapter; a clear request blanks the whole grid first.

module cell_plotter #(
  parameter int GRID_W     = 4,
  parameter int GRID_H     = 4,
  parameter int CELL_SIZE  = 4,
  parameter int X_ORIGIN   = 0,
  parameter int Y_ORIGIN   = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [7:0] in_y,
  input  logic [2:0] in_colour,
  input  logic       clear_req,
  output logic       plot,
  output logic [7:0] out_x,
  output logic [7:0] out_y,
  output logic [2:0] out_colour,
  output logic       busy,
  output logic [7:0] dropped_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  localparam logic [7:0] GW8     = 8'(GRID_W);
  localparam logic [7:0] GH8     = 8'(GRID_H);
  localparam logic [7:0] CS8     = 8'(CELL_SIZE);
  localparam logic [7:0] CS_M1   = 8'(CELL_SIZE - 1);
  localparam logic [7:0] CLR_XM1 = 8'(GRID_W * CELL_SIZE - 1);
  localparam logic [7:0] CLR_YM1 = 8'(GRID_H * CELL_SIZE - 1);
  localparam logic [7:0] XO8     = 8'(X_ORIGIN);
  localparam logic [7:0] YO8     = 8'(Y_ORIGIN);

  if ((X_ORIGIN + GRID_W * CELL_SIZE > 160) ||
      (Y_ORIGIN + GRID_H * CELL_SIZE > 120)) begin : g_bad_geometry
    $error("cell_plotter: grid does not fit in 160x120");
  end

  if ((FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("cell_plotter: FIFO_DEPTH must be a power of 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAINT,
    S_CLEAR
  } state_t;

  state_t r_state;

  logic [18:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;

  logic       r_pending;
  logic [7:0] r_dropped;
  logic [7:0] r_base_x;
  logic [7:0] r_base_y;
  logic [2:0] r_colour;
  logic [7:0] r_px;
  logic [7:0] r_py;

  logic       r_plot;
  logic [7:0] r_out_x;
  logic [7:0] r_out_y;
  logic [2:0] r_out_colour;

  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic [18:0] w_head;
  logic [7:0]  w_head_x;
  logic [7:0]  w_head_y;
  logic [2:0]  w_head_c;
  logic        w_in_range;
  logic [7:0]  w_base_x;
  logic [7:0]  w_base_y;
  logic        w_paint_last;
  logic        w_clear_last;

  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count < FULL);
  assign w_push   = in_valid && in_ready && reset_n;
  assign w_pop    = (r_state == S_IDLE) && !r_pending && !w_empty;

  assign w_head = r_mem[r_rd];
  assign {w_head_x, w_head_y, w_head_c} = w_head;

  assign w_in_range = (w_head_x < GW8) && (w_head_y < GH8);
  assign w_base_x   = XO8 + w_head_x * CS8;
  assign w_base_y   = YO8 + w_head_y * CS8;

  assign w_paint_last = (r_px == CS_M1) && (r_py == CS_M1);
  assign w_clear_last = (r_px == CLR_XM1) && (r_py == CLR_YM1);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr] <= {in_x, in_y, in_colour};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_pending    <= 1'b0;
      r_dropped    <= '0;
      r_base_x     <= '0;
      r_base_y     <= '0;
      r_colour     <= '0;
      r_px         <= '0;
      r_py         <= '0;
      r_plot       <= 1'b0;
      r_out_x      <= '0;
      r_out_y      <= '0;
      r_out_colour <= '0;
    end else begin
      r_plot <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // A pending clear is serviced before any queued cell.
          if (r_pending) begin
            r_pending <= 1'b0;
            r_state   <= S_CLEAR;
            r_px      <= '0;
            r_py      <= '0;
          end else begin
            if (clear_req) begin
              r_pending <= 1'b1;
            end
            if (w_pop) begin
              r_base_x <= w_base_x;
              r_base_y <= w_base_y;
              r_colour <= w_head_c;
              r_px     <= '0;
              r_py     <= '0;
              if (w_in_range) begin
                r_state <= S_PAINT;
              end else if (r_dropped != 8'hFF) begin
                r_dropped <= r_dropped + 8'd1;
              end
            end
          end
        end
        S_PAINT: begin
          if (clear_req) begin
            r_pending <= 1'b1;
          end
          r_plot       <= 1'b1;
          r_out_x      <= r_base_x + r_px;
          r_out_y      <= r_base_y + r_py;
          r_out_colour <= r_colour;
          if (r_px == CS_M1) begin
            r_px <= '0;
            r_py <= r_py + 8'd1;
          end else begin
            r_px <= r_px + 8'd1;
          end
          if (w_paint_last) begin
            r_state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          r_plot       <= 1'b1;
          r_out_x      <= XO8 + r_px;
          r_out_y      <= YO8 + r_py;
          r_out_colour <= 3'b000;
          if (r_px == CLR_XM1) begin
            r_px <= '0;
            r_py <= r_py + 8'd1;
          end else begin
            r_px <= r_px + 8'd1;
          end
          if (w_clear_last) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign plot          = r_plot;
  assign out_x         = r_out_x;
  assign out_y         = r_out_y;
  assign out_colour    = r_out_colour;
  assign dropped_count = r_dropped;
  assign busy = (r_state != S_IDLE) || !w_empty || r_pending;

endmodule

// File: tb/tb_cell_plotter.sv
// Bench for cell_plotter: directed and random cell updates checked
// against a pixel-list model of the grid painter.

module tb_cell_plotter;

  localparam int GW = 4;
  localparam int GH = 4;
  localparam int CS = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_x = '0;
  logic [7:0] in_y = '0;
  logic [2:0] in_colour = '0;
  logic       clear_req = 1'b0;
  logic       in_ready;
  logic       plot;
  logic [7:0] out_x;
  logic [7:0] out_y;
  logic [2:0] out_colour;
  logic       busy;
  logic [7:0] dropped_count;

  cell_plotter dut (
    .clock(clock),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_x(in_x),
    .in_y(in_y),
    .in_colour(in_colour),
    .clear_req(clear_req),
    .plot(plot),
    .out_x(out_x),
    .out_y(out_y),
    .out_colour(out_colour),
    .busy(busy),
    .dropped_count(dropped_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [18:0] cap[$];
  int          cap_cyc[$];
  logic [18:0] exp_q[$];

  always @(negedge clock) begin
    if (plot === 1'b1) begin
      cap.push_back({out_x, out_y, out_colour});
      cap_cyc.push_back(cyc);
    end
  end

  int pass_n = 0;
  int total_n = 0;
  int exp_drop = 0;
  int acc_edge = 0;

  function automatic void model_cell(int x, int y, int c);
    if (x < GW && y < GH) begin
      for (int py = 0; py < CS; py++)
        for (int px = 0; px < CS; px++)
          exp_q.push_back({8'(x * CS + px), 8'(y * CS + py), 3'(c)});
    end else if (exp_drop < 255) begin
      exp_drop++;
    end
  endfunction

  function automatic void model_clear();
    for (int y = 0; y < GH * CS; y++)
      for (int x = 0; x < GW * CS; x++)
        exp_q.push_back({8'(x), 8'(y), 3'b000});
  endfunction

  function automatic int first_diff();
    int n;
    n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (cap[i] !== exp_q[i]) return i;
    if (cap.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [18:0] got_at(int i);
    return (i >= 0 && i < cap.size()) ? cap[i] : 19'h7ffff;
  endfunction

  function automatic logic [18:0] exp_at(int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 19'h7ffff;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start_scn();
    cap.delete();
    cap_cyc.delete();
    exp_q.delete();
  endtask

  task automatic push(input int x, input int y, input int c);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_x = 8'(x);
    in_y = 8'(y);
    in_colour = 3'(c);
    while (in_ready !== 1'b1 && w < 2000) begin
      @(negedge clock);
      w++;
    end
    if (in_ready !== 1'b1) begin
      total_n++;
      $display("FAIL push_ready: in_ready=%b after %0d cycles, want 1",
               in_ready, w);
    end
    acc_edge = cyc + 1;
    @(negedge clock);
    in_valid = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    while (busy !== 1'b0 && w < budget) begin
      @(negedge clock);
      w++;
    end
    if (busy !== 1'b0) begin
      total_n++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, want 0",
               busy, budget);
    end
    tick(3);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b1;
    in_x = 8'd1;
    in_y = 8'd1;
    in_colour = 3'd5;
    tick(3);
    in_valid = 1'b0;
    reset_n = 1'b1;
    tick(1);
    total_n++;
    if (plot !== 1'b0) $display("FAIL rst_plot: got %b want 0", plot);
    else pass_n++;
    total_n++;
    if ({out_x, out_y, out_colour} !== 19'd0)
      $display("FAIL rst_out: got %h want 0", {out_x, out_y, out_colour});
    else pass_n++;
    total_n++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
    else pass_n++;
    total_n++;
    if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready);
    else pass_n++;
    total_n++;
    if (dropped_count !== 8'd0)
      $display("FAIL rst_dropped: got %0d want 0", dropped_count);
    else pass_n++;
    tick(20);
    total_n++;
    if (cap.size() != 0)
      $display("FAIL rst_no_accept: got %0d plots want 0", cap.size());
    else pass_n++;
  endtask

  task automatic test_single();
    int d;
    start_scn();
    model_cell(1, 2, 7);
    push(1, 2, 7);
    tick(4);
    total_n++;
    if (busy !== 1'b1) $display("FAIL single_busy_mid: got %b want 1", busy);
    else pass_n++;
    wait_idle(200);
    total_n++;
    if (cap_cyc.size() == 0 || cap_cyc[0] != acc_edge + 2)
      $display("FAIL single_latency: first plot edge %0d want %0d",
               (cap_cyc.size() == 0) ? -1 : cap_cyc[0], acc_edge + 2);
    else pass_n++;
    d = first_diff();
    total_n++;
    if (d != -1)
      $display("FAIL single_stream: px %0d got %h want %h (%0d/%0d px)",
               d, got_at(d), exp_at(d), cap.size(), exp_q.size());
    else pass_n++;
    total_n++;
    if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy);
    else pass_n++;
  endtask

  task automatic test_drop();
    start_scn();
    model_cell(4, 0, 7);
    push(4, 0, 7);
    wait_idle(100);
    total_n++;
    if (cap.size() != 0)
      $display("FAIL drop_noplot: got %0d plots want 0", cap.size());
    else pass_n++;
    total_n++;
    if (dropped_count !== 8'(exp_drop))
      $display("FAIL drop_count: got %0d want %0d", dropped_count, exp_drop);
    else pass_n++;
    total_n++;
    if (busy !== 1'b0) $display("FAIL drop_busy: got %b want 0", busy);
    else pass_n++;
  endtask

  task automatic test_back_to_back();
    int d;
    int xs[10];
    int ys[10];
    int cs[10];
    start_scn();
    for (int i = 0; i < 10; i++) begin
      xs[i] = $urandom_range(0, GW - 1);
      ys[i] = $urandom_range(0, GH - 1);
      cs[i] = $urandom_range(0, 7);
      model_cell(xs[i], ys[i], cs[i]);
    end
    for (int i = 0; i < 9; i++) push(xs[i], ys[i], cs[i]);
    total_n++;
    if (in_ready !== 1'b0) $display("FAIL b2b_full: got %b want 0", in_ready);
    else pass_n++;
    push(xs[9], ys[9], cs[9]);
    wait_idle(1000);
    d = first_diff();
    total_n++;
    if (d != -1)
      $display("FAIL b2b_stream: px %0d got %h want %h (%0d/%0d px)",
               d, got_at(d), exp_at(d), cap.size(), exp_q.size());
    else pass_n++;
  endtask

  task automatic test_clear();
    int d;
    start_scn();
    model_clear();
    model_cell(3, 0, 2);
    model_cell(0, 3, 5);
    clear_req = 1'b1;
    push(3, 0, 2);
    push(0, 3, 5);
    wait_idle(1000);
    d = first_diff();
    total_n++;
    if (d != -1)
      $display("FAIL clear_stream: px %0d got %h want %h (%0d/%0d px)",
               d, got_at(d), exp_at(d), cap.size(), exp_q.size());
    else pass_n++;
  endtask

  task automatic test_push_pop();
    int d;
    int e0;
    int xs[10];
    int ys[10];
    int cs[10];
    start_scn();
    for (int i = 0; i < 10; i++) begin
      xs[i] = $urandom_range(0, GW - 1);
      ys[i] = $urandom_range(0, GH - 1);
      cs[i] = $urandom_range(0, 7);
      model_cell(xs[i], ys[i], cs[i]);
    end
    push(xs[0], ys[0], cs[0]);
    e0 = acc_edge;
    for (int i = 1; i < 4; i++) push(xs[i], ys[i], cs[i]);
    while (cyc < e0 + 17) @(negedge clock);
    for (int i = 4; i < 10; i++) push(xs[i], ys[i], cs[i]);
    total_n++;
    if (in_ready !== 1'b0)
      $display("FAIL pushpop_occupancy: in_ready got %b want 0", in_ready);
    else pass_n++;
    wait_idle(1000);
    d = first_diff();
    total_n++;
    if (d != -1)
      $display("FAIL pushpop_stream: px %0d got %h want %h (%0d/%0d px)",
               d, got_at(d), exp_at(d), cap.size(), exp_q.size());
    else pass_n++;
  endtask

  task automatic test_random();
    int d;
    int x;
    int y;
    int c;
    start_scn();
    for (int i = 0; i < 14; i++) begin
      x = $urandom_range(0, 5);
      y = $urandom_range(0, 5);
      c = $urandom_range(0, 7);
      model_cell(x, y, c);
      push(x, y, c);
      tick($urandom_range(0, 20));
    end
    wait_idle(3000);
    d = first_diff();
    total_n++;
    if (d != -1)
      $display("FAIL rand_stream: px %0d got %h want %h (%0d/%0d px)",
               d, got_at(d), exp_at(d), cap.size(), exp_q.size());
    else pass_n++;
    total_n++;
    if (dropped_count !== 8'(exp_drop))
      $display("FAIL rand_dropped: got %0d want %0d", dropped_count, exp_drop);
    else pass_n++;
  endtask

  task automatic test_saturate();
    start_scn();
    for (int i = 0; i < 260; i++) begin
      model_cell(200, i % 8, 1);
      push(200, i % 8, 1);
    end
    wait_idle(1000);
    total_n++;
    if (dropped_count !== 8'(exp_drop) || exp_drop != 255)
      $display("FAIL sat_dropped: got %0d want 255", dropped_count);
    else pass_n++;
  endtask

  task automatic test_reset_mid_paint();
    int w;
    start_scn();
    push(2, 1, 3);
    push(0, 0, 5);
    push(3, 3, 6);
    w = 0;
    while (cap.size() < 5 && w < 100) begin
      @(negedge clock);
      #1;
      w++;
    end
    total_n++;
    if (cap.size() != 5)
      $display("FAIL mid_pixel5: got %0d plots want 5", cap.size());
    else pass_n++;
    reset_n = 1'b0;
    exp_drop = 0;
    tick(1);
    total_n++;
    if (plot !== 1'b0) $display("FAIL mid_plot: got %b want 0", plot);
    else pass_n++;
    total_n++;
    if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy);
    else pass_n++;
    total_n++;
    if (in_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", in_ready);
    else pass_n++;
    total_n++;
    if (dropped_count !== 8'(exp_drop))
      $display("FAIL mid_dropped: got %0d want 0", dropped_count);
    else pass_n++;
    reset_n = 1'b1;
    tick(60);
    total_n++;
    if (cap.size() != 5)
      $display("FAIL mid_abandon: got %0d plots want 5", cap.size());
    else pass_n++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_drop();
    test_back_to_back();
    test_clear();
    test_push_pop();
    test_random();
    test_saturate();
    test_reset_mid_paint();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
